// File: rtl/core_ex_mc_pkg.sv
// Shared constants for the xRV32I execute stage with RV32M support.
// Holds the opcode/func3/func7 codes used by core_ex_mc and the
// state encoding of its multicycle FSM.
package core_ex_mc_pkg;

  // Opcodes
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
  localparam logic [6:0] INST_JAL      = 7'b1101111;
  localparam logic [6:0] INST_JALR     = 7'b1100111;
  localparam logic [6:0] INST_TYPE_B   = 7'b1100011;

  // M-extension func7
  localparam logic [6:0] INST_FUNC7_M  = 7'b0000001;

  // M-extension func3
  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  // Branch func3
  localparam logic [2:0] INST_FUNC3_BEQ  = 3'b000;
  localparam logic [2:0] INST_FUNC3_BNE  = 3'b001;
  localparam logic [2:0] INST_FUNC3_BLT  = 3'b100;
  localparam logic [2:0] INST_FUNC3_BGE  = 3'b101;
  localparam logic [2:0] INST_FUNC3_BLTU = 3'b110;
  localparam logic [2:0] INST_FUNC3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } ex_state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_e;

endpackage

// File: rtl/core_ex_muldiv.sv
// Iterative unsigned multiplier (shift-add) / restoring divider.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       latch a/b/op and begin (ignored while abort is high)
//   abort       drop the operation in flight
//   op          0 = multiply, 1 = divide
//   a, b        unsigned operands (multiplicand/multiplier, dividend/divisor)
//   done        high during the final iteration cycle
//   result      value after this cycle's iteration: {hi, lo} product or
//               {remainder, quotient}; valid when done is high
module core_ex_muldiv
  import core_ex_mc_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ITER_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              done,
  output logic [2*XLEN-1:0] result
);

  localparam int unsigned STEPS = XLEN / ITER_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  logic [2*XLEN-1:0] p_q, p_nx;
  logic [XLEN-1:0]   b_q;
  logic              op_q;
  logic              busy;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN:0]     hi_t;
  logic [XLEN:0]     tr_t;

  // p_q holds {acc, multiplier} for multiply and {rem, dividend/quotient}
  // for divide; both retire one bit per inner iteration from the low half.
  always_comb begin
    p_nx = p_q;
    hi_t = '0;
    tr_t = '0;
    for (int unsigned i = 0; i < ITER_BITS; i++) begin
      if (op_q == MD_MUL) begin
        hi_t = {1'b0, p_nx[2*XLEN-1:XLEN]} + (p_nx[0] ? {1'b0, b_q} : '0);
        p_nx = {hi_t, p_nx[XLEN-1:1]};
      end else begin
        tr_t = {p_nx[2*XLEN-1:XLEN], p_nx[XLEN-1]};
        if (tr_t >= {1'b0, b_q}) begin
          tr_t = tr_t - {1'b0, b_q};
          p_nx = {tr_t[XLEN-1:0], p_nx[XLEN-2:0], 1'b1};
        end else begin
          p_nx = {tr_t[XLEN-1:0], p_nx[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign done   = busy && (cnt_q == CNT_W'(STEPS - 1));
  assign result = p_nx;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy  <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt_q <= '0;
      p_q   <= {{XLEN{1'b0}}, a};
      b_q   <= b;
      op_q  <= op;
    end else if (busy) begin
      p_q   <= p_nx;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/core_ex_mc.sv
// Registered execute stage for xRV32I with iterative RV32M.
// Resolves branches/JAL/JALR, forwards ALU results, and runs MUL/DIV
// through core_ex_muldiv while holding the pipeline.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake from core_id
//   flush_in                 kill from core_ctrl
//   inst_addr_in .. reg_write_addr_in   decoded instruction fields
//   out_valid                one-cycle result strobe
//   reg_we_out/_addr/_data   write-back to core_regs
//   jump_flag_out/_addr_out  redirect to core_ctrl
//   hold_flag_out            stall while a multicycle op runs
module core_ex_mc
  import core_ex_mc_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     REG_ADDR_W = 5,
  parameter int unsigned     ITER_BITS  = 1,
  parameter logic [XLEN-1:0] RST_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush_in,
  input  logic [XLEN-1:0]       inst_addr_in,
  input  logic [6:0]            opcode_in,
  input  logic [2:0]            func3_in,
  input  logic [6:0]            func7_in,
  input  logic [XLEN-1:0]       reg1_data_in,
  input  logic [XLEN-1:0]       reg2_data_in,
  input  logic [XLEN-1:0]       imm_in,
  input  logic [XLEN-1:0]       alu_result_in,
  input  logic                  reg_we_in,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
  output logic                  out_valid,
  output logic                  reg_we_out,
  output logic [REG_ADDR_W-1:0] reg_write_addr_out,
  output logic [XLEN-1:0]       reg_write_data_out,
  output logic                  jump_flag_out,
  output logic [XLEN-1:0]       jump_addr_out,
  output logic                  hold_flag_out
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  ex_state_e state_q, state_d;

  logic accept, is_m, fast, md_start, md_done, br_taken;
  logic signed_div, a_sgn, b_sgn, a_neg, b_neg, res_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_abs, b_abs, fast_data, jalr_sum, md_data, q_raw, r_raw;
  logic [2*XLEN-1:0] md_result, mul_fix;

  logic [2:0]            m_func3_q;
  logic                  m_neg_q, m_we_q;
  logic [REG_ADDR_W-1:0] m_rd_q;

  logic                  ov_d, we_d, jf_d, hold_d;
  logic [REG_ADDR_W-1:0] addr_d;
  logic [XLEN-1:0]       data_d, ja_d;

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready && !flush_in;
  assign is_m     = (opcode_in == INST_TYPE_R_M) && (func7_in == INST_FUNC7_M);

  // Signedness of each operand; the unit works on magnitudes and the
  // result sign is restored from res_neg when it finishes.
  assign signed_div = ~func3_in[0];
  assign a_sgn = func3_in[2] ? signed_div
                             : ((func3_in == INST_MULH) || (func3_in == INST_MULHSU));
  assign b_sgn = func3_in[2] ? signed_div : (func3_in == INST_MULH);
  assign a_neg = a_sgn && reg1_data_in[XLEN-1];
  assign b_neg = b_sgn && reg2_data_in[XLEN-1];
  assign a_abs = a_neg ? -reg1_data_in : reg1_data_in;
  assign b_abs = b_neg ? -reg2_data_in : reg2_data_in;
  // Remainder takes the dividend's sign; everything else the XOR.
  assign res_neg = (func3_in[2] && func3_in[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero  = (reg2_data_in == '0);
  assign div_ovf   = signed_div && (reg1_data_in == INT_MIN) && (reg2_data_in == '1);
  assign fast      = func3_in[2] && (div_zero || div_ovf);
  assign fast_data = func3_in[1] ? (div_zero ? reg1_data_in : '0)
                                 : (div_zero ? '1 : INT_MIN);

  assign md_start = accept && is_m && !fast;
  assign jalr_sum = reg1_data_in + imm_in;

  core_ex_muldiv #(
    .XLEN      (XLEN),
    .ITER_BITS (ITER_BITS)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .abort  (flush_in),
    .op     (func3_in[2]),
    .a      (a_abs),
    .b      (b_abs),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    case (func3_in)
      INST_FUNC3_BEQ:  br_taken = (reg1_data_in == reg2_data_in);
      INST_FUNC3_BNE:  br_taken = (reg1_data_in != reg2_data_in);
      INST_FUNC3_BLT:  br_taken = ($signed(reg1_data_in) <  $signed(reg2_data_in));
      INST_FUNC3_BGE:  br_taken = ($signed(reg1_data_in) >= $signed(reg2_data_in));
      INST_FUNC3_BLTU: br_taken = (reg1_data_in <  reg2_data_in);
      INST_FUNC3_BGEU: br_taken = (reg1_data_in >= reg2_data_in);
      default:         br_taken = 1'b0;
    endcase
  end

  assign mul_fix = m_neg_q ? -md_result : md_result;
  assign q_raw   = md_result[XLEN-1:0];
  assign r_raw   = md_result[2*XLEN-1:XLEN];

  always_comb begin
    case (m_func3_q)
      INST_MUL:                          md_data = mul_fix[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: md_data = mul_fix[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:               md_data = m_neg_q ? -q_raw : q_raw;
      default:                           md_data = m_neg_q ? -r_raw : r_raw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ov_d    = 1'b0;
    we_d    = 1'b0;
    jf_d    = 1'b0;
    hold_d  = 1'b0;
    addr_d  = reg_write_addr_out;
    data_d  = reg_write_data_out;
    ja_d    = RST_ADDR;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_m && !fast) begin
            state_d = func3_in[2] ? S_DIV : S_MUL;
            hold_d  = 1'b1;
          end else begin
            ov_d   = 1'b1;
            we_d   = reg_we_in;
            addr_d = reg_write_addr_in;
            data_d = '0;
            if (is_m) begin
              data_d = fast_data;
            end else begin
              case (opcode_in)
                INST_TYPE_R_M, INST_TYPE_I: data_d = alu_result_in;
                INST_JAL: begin
                  jf_d   = 1'b1;
                  ja_d   = inst_addr_in + imm_in;
                  data_d = inst_addr_in + XLEN'(4);
                end
                INST_JALR: begin
                  jf_d   = 1'b1;
                  ja_d   = {jalr_sum[XLEN-1:1], 1'b0};
                  data_d = inst_addr_in + XLEN'(4);
                end
                INST_TYPE_B: begin
                  we_d = 1'b0;
                  if (br_taken) begin
                    jf_d = 1'b1;
                    ja_d = inst_addr_in + imm_in;
                  end
                end
                default: data_d = '0;
              endcase
            end
          end
        end
      end
      S_MUL, S_DIV: begin
        if (flush_in) begin
          state_d = S_IDLE;
        end else if (md_done) begin
          state_d = S_IDLE;
          ov_d    = 1'b1;
          we_d    = m_we_q;
          addr_d  = m_rd_q;
          data_d  = md_data;
        end else begin
          hold_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      out_valid          <= 1'b0;
      reg_we_out         <= 1'b0;
      reg_write_addr_out <= '0;
      reg_write_data_out <= '0;
      jump_flag_out      <= 1'b0;
      jump_addr_out      <= RST_ADDR;
      hold_flag_out      <= 1'b0;
    end else begin
      state_q            <= state_d;
      out_valid          <= ov_d;
      reg_we_out         <= we_d;
      reg_write_addr_out <= addr_d;
      reg_write_data_out <= data_d;
      jump_flag_out      <= jf_d;
      jump_addr_out      <= ja_d;
      hold_flag_out      <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (md_start) begin
      m_func3_q <= func3_in;
      m_neg_q   <= res_neg;
      m_we_q    <= reg_we_in;
      m_rd_q    <= reg_write_addr_in;
    end
  end

endmodule

// File: tb/tb_core_ex_mc.sv
module tb_core_ex_mc;

  localparam int          XLEN  = 32;
  localparam int          RA    = 5;
  localparam int          ITER  = 1;
  localparam logic [31:0] RST_A = 32'h0000_0080;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] F7M  = 7'b0000001;

  logic            clk, rst, in_valid, in_ready, flush_in;
  logic [31:0]     inst_addr_in, reg1_data_in, reg2_data_in, imm_in, alu_result_in;
  logic [6:0]      opcode_in, func7_in;
  logic [2:0]      func3_in;
  logic            reg_we_in;
  logic [RA-1:0]   reg_write_addr_in;
  logic            out_valid, reg_we_out, jump_flag_out, hold_flag_out;
  logic [RA-1:0]   reg_write_addr_out;
  logic [31:0]     reg_write_data_out, jump_addr_out;

  core_ex_mc #(
    .XLEN       (XLEN),
    .REG_ADDR_W (RA),
    .ITER_BITS  (ITER),
    .RST_ADDR   (RST_A)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .flush_in           (flush_in),
    .inst_addr_in       (inst_addr_in),
    .opcode_in          (opcode_in),
    .func3_in           (func3_in),
    .func7_in           (func7_in),
    .reg1_data_in       (reg1_data_in),
    .reg2_data_in       (reg2_data_in),
    .imm_in             (imm_in),
    .alu_result_in      (alu_result_in),
    .reg_we_in          (reg_we_in),
    .reg_write_addr_in  (reg_write_addr_in),
    .out_valid          (out_valid),
    .reg_we_out         (reg_we_out),
    .reg_write_addr_out (reg_write_addr_out),
    .reg_write_data_out (reg_write_data_out),
    .jump_flag_out      (jump_flag_out),
    .jump_addr_out      (jump_addr_out),
    .hold_flag_out      (hold_flag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc, rs1, rs2, imm, alu;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] e_data;
    logic        e_we;
    logic        e_jf;
    logic [31:0] e_ja;
    logic        chk_data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [4:0]  rd;
    logic        jf;
    logic [31:0] ja;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] imm, logic [31:0] alu, logic we, logic [4:0] rd,
                              logic [31:0] ed, logic ewe, logic ejf, logic [31:0] eja,
                              logic cd);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.alu = alu; v.we = we; v.rd = rd; v.e_data = ed;
    v.e_we = ewe; v.e_jf = ejf; v.e_ja = eja; v.chk_data = cd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    opcode_in = v.op; func3_in = v.f3; func7_in = v.f7;
    inst_addr_in = v.pc; reg1_data_in = v.rs1; reg2_data_in = v.rs2;
    imm_in = v.imm; alu_result_in = v.alu; reg_we_in = v.we;
    reg_write_addr_in = v.rd; in_valid = 1'b1;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    apply(v);
    e.data = v.e_data; e.we = v.e_we; e.rd = v.rd; e.jf = v.e_jf;
    e.ja = v.e_ja; e.chk_data = v.chk_data;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_reg_we"}, reg_we_out, 0);
    check({tag, "_jump_flag"}, jump_flag_out, 0);
    check({tag, "_hold"}, hold_flag_out, 0);
    check({tag, "_addr"}, reg_write_addr_out, 0);
    check({tag, "_data"}, reg_write_data_out, 0);
    check({tag, "_jump_addr"}, jump_addr_out, RST_A);
  endtask

  // Output monitor: every result strobe must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 (nothing pending)");
        end else begin
          e = sb.pop_front();
          if (e.chk_data) check("wb_data", reg_write_data_out, e.data);
          check("wb_we", reg_we_out, e.we);
          check("wb_addr", reg_write_addr_out, e.rd);
          check("jump_flag", jump_flag_out, e.jf);
          check("jump_addr", jump_addr_out, e.ja);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[18];
  vec_t mc[10];

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush_in = 1'b0;
    opcode_in = '0; func3_in = '0; func7_in = '0; inst_addr_in = '0;
    reg1_data_in = '0; reg2_data_in = '0; imm_in = '0; alu_result_in = '0;
    reg_we_in = 1'b0; reg_write_addr_in = '0;

    vt[0]  = mk(OP,   3'd0, 7'h00, 32'h0,   32'h0,        32'h0,        32'h0,        32'h5,    1'b1, 5'd3, 32'h5,        1'b1, 1'b0, RST_A,        1'b1);
    vt[1]  = mk(OP,   3'd0, 7'h20, 32'h0,   32'h9,        32'h6,        32'h0,        32'h3,    1'b1, 5'd4, 32'h3,        1'b1, 1'b0, RST_A,        1'b1);
    vt[2]  = mk(BR,   3'd4, 7'h00, 32'h100, 32'hFFFFFFFF, 32'h1,        32'h20,       32'h0,    1'b1, 5'd0, 32'h0,        1'b0, 1'b1, 32'h120,      1'b0);
    vt[3]  = mk(BR,   3'd6, 7'h00, 32'h100, 32'hFFFFFFFF, 32'h1,        32'h20,       32'h0,    1'b1, 5'd0, 32'h0,        1'b0, 1'b0, RST_A,        1'b0);
    vt[4]  = mk(JALR, 3'd0, 7'h00, 32'h40,  32'h203,      32'h0,        32'h0,        32'h0,    1'b1, 5'd1, 32'h44,       1'b1, 1'b1, 32'h202,      1'b1);
    vt[5]  = mk(JAL,  3'd0, 7'h00, 32'h200, 32'h0,        32'h0,        32'hFFFFFFF0, 32'h0,    1'b1, 5'd2, 32'h204,      1'b1, 1'b1, 32'h1F0,      1'b1);
    vt[6]  = mk(BR,   3'd0, 7'h00, 32'h300, 32'h5,        32'h5,        32'h8,        32'h0,    1'b1, 5'd0, 32'h0,        1'b0, 1'b1, 32'h308,      1'b0);
    vt[7]  = mk(BR,   3'd1, 7'h00, 32'h300, 32'h5,        32'h5,        32'h8,        32'h0,    1'b1, 5'd0, 32'h0,        1'b0, 1'b0, RST_A,        1'b0);
    vt[8]  = mk(BR,   3'd5, 7'h00, 32'h10,  32'h1,        32'hFFFFFFFF, 32'h10,       32'h0,    1'b1, 5'd0, 32'h0,        1'b0, 1'b1, 32'h20,       1'b0);
    vt[9]  = mk(BR,   3'd7, 7'h00, 32'h10,  32'h1,        32'hFFFFFFFF, 32'h10,       32'h0,    1'b1, 5'd0, 32'h0,        1'b0, 1'b0, RST_A,        1'b0);
    vt[10] = mk(OPI,  3'd0, 7'h00, 32'h0,   32'h0,        32'h0,        32'h0,        32'h1234, 1'b1, 5'd0, 32'h1234,     1'b1, 1'b0, RST_A,        1'b1);
    vt[11] = mk(LUI,  3'd0, 7'h00, 32'h0,   32'h0,        32'h0,        32'h0,        32'hDEAD, 1'b0, 5'd7, 32'h0,        1'b0, 1'b0, RST_A,        1'b1);
    vt[12] = mk(OP,   3'd4, F7M,   32'h0,   32'h7,        32'h0,        32'h0,        32'hAAAA, 1'b1, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b0, RST_A,        1'b1);
    vt[13] = mk(OP,   3'd6, F7M,   32'h0,   32'h7,        32'h0,        32'h0,        32'hAAAA, 1'b1, 5'd5, 32'h7,        1'b1, 1'b0, RST_A,        1'b1);
    vt[14] = mk(OP,   3'd4, F7M,   32'h0,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'hAAAA, 1'b1, 5'd6, 32'h80000000, 1'b1, 1'b0, RST_A,        1'b1);
    vt[15] = mk(OP,   3'd6, F7M,   32'h0,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'hAAAA, 1'b1, 5'd6, 32'h0,        1'b1, 1'b0, RST_A,        1'b1);
    vt[16] = mk(OP,   3'd5, F7M,   32'h0,   32'h7,        32'h0,        32'h0,        32'hAAAA, 1'b1, 5'd8, 32'hFFFFFFFF, 1'b1, 1'b0, RST_A,        1'b1);
    vt[17] = mk(OP,   3'd7, F7M,   32'h0,   32'h7,        32'h0,        32'h0,        32'hAAAA, 1'b1, 5'd8, 32'h7,        1'b1, 1'b0, RST_A,        1'b1);

    mc[0] = mk(OP, 3'd3, F7M, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h55, 1'b1, 5'd9,  32'hFFFFFFFE, 1'b1, 1'b0, RST_A, 1'b1);
    mc[1] = mk(OP, 3'd1, F7M, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h55, 1'b1, 5'd10, 32'h0,        1'b1, 1'b0, RST_A, 1'b1);
    mc[2] = mk(OP, 3'd2, F7M, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h55, 1'b1, 5'd11, 32'hFFFFFFFF, 1'b1, 1'b0, RST_A, 1'b1);
    mc[3] = mk(OP, 3'd1, F7M, 32'h0, 32'h40000000, 32'h4,        32'h0, 32'h55, 1'b1, 5'd12, 32'h1,        1'b1, 1'b0, RST_A, 1'b1);
    mc[4] = mk(OP, 3'd0, F7M, 32'h0, 32'h12345678, 32'h10,       32'h0, 32'h55, 1'b1, 5'd13, 32'h23456780, 1'b1, 1'b0, RST_A, 1'b1);
    mc[5] = mk(OP, 3'd4, F7M, 32'h0, 32'hFFFFFF9C, 32'h7,        32'h0, 32'h55, 1'b1, 5'd14, 32'hFFFFFFF2, 1'b1, 1'b0, RST_A, 1'b1);
    mc[6] = mk(OP, 3'd6, F7M, 32'h0, 32'hFFFFFF9C, 32'h7,        32'h0, 32'h55, 1'b1, 5'd15, 32'hFFFFFFFE, 1'b1, 1'b0, RST_A, 1'b1);
    mc[7] = mk(OP, 3'd4, F7M, 32'h0, 32'h64,       32'hFFFFFFF9, 32'h0, 32'h55, 1'b1, 5'd16, 32'hFFFFFFF2, 1'b1, 1'b0, RST_A, 1'b1);
    mc[8] = mk(OP, 3'd6, F7M, 32'h0, 32'h64,       32'hFFFFFFF9, 32'h0, 32'h55, 1'b1, 5'd17, 32'h2,        1'b1, 1'b0, RST_A, 1'b1);
    mc[9] = mk(OP, 3'd5, F7M, 32'h0, 32'hFFFFFFFF, 32'h2,        32'h0, 32'h55, 1'b1, 5'd18, 32'h7FFFFFFF, 1'b1, 1'b0, RST_A, 1'b1);

    // Reset state
    tick(); tick();
    check("in_ready_during_rst", in_ready, 0);
    check_reset_vals("rst");
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Single-cycle table, back to back
    for (int i = 0; i < 18; i++) begin
      drive(vt[i]);
      tick();
    end
    in_valid = 1'b0;
    drain(10);

    // MUL -3 * 7 with hold/ready timing
    drive(mk(OP, 3'd0, F7M, 32'h0, 32'hFFFFFFFD, 32'h7, 32'h0, 32'h55, 1'b1, 5'd3,
             32'hFFFFFFEB, 1'b1, 1'b0, RST_A, 1'b1));
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("mul_hold_c%0d", c), hold_flag_out, 1);
      check($sformatf("mul_ready_c%0d", c), in_ready, 0);
      check($sformatf("mul_ovalid_c%0d", c), out_valid, 0);
      tick();
    end
    check("mul_ovalid_c33", out_valid, 1);
    check("mul_hold_c33", hold_flag_out, 0);
    check("mul_ready_c33", in_ready, 1);
    drain(5);

    // Further multicycle ops
    for (int i = 0; i < 10; i++) begin
      drive(mc[i]);
      tick();
      in_valid = 1'b0;
      drain(40);
    end

    // DIV 100/7 killed by flush at cycle 10
    apply(mk(OP, 3'd4, F7M, 32'h0, 32'h64, 32'h7, 32'h0, 32'h55, 1'b1, 5'd20,
             32'h0, 1'b0, 1'b0, RST_A, 1'b0));
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    check("flush_hold_c10", hold_flag_out, 1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check("flush_ovalid_c11", out_valid, 0);
    check("flush_hold_c11", hold_flag_out, 0);
    check("flush_jf_c11", jump_flag_out, 0);
    check("flush_ready_c11", in_ready, 1);
    repeat (40) tick();

    // Flush while idle squashes the acceptance
    drive(vt[0]);
    sb.delete();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    in_valid = 1'b0;
    check("idle_flush_ovalid", out_valid, 0);
    tick();

    // DIV 100/7 aborted by rst at cycle 10
    apply(mk(OP, 3'd4, F7M, 32'h0, 32'h64, 32'h7, 32'h0, 32'h55, 1'b1, 5'd21,
             32'h0, 1'b0, 1'b0, RST_A, 1'b0));
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1);

    // REMU 100/7 after reset
    drive(mk(OP, 3'd7, F7M, 32'h0, 32'h64, 32'h7, 32'h0, 32'h55, 1'b1, 5'd22,
             32'h2, 1'b1, 1'b0, RST_A, 1'b1));
    tick();
    in_valid = 1'b0;
    drain(40);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
